// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_pkg
// Purpose : Shared definitions for the bit-serial adder: FSM state encoding
//           and the default operand width.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

   // Default operand/sum width in bits.
   localparam int DEFAULT_WIDTH = 16;

   // FSM state encoding. The values are fixed so that a state register can
   // be stored in a plain 2-bit flop cell and cast back to the enum.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_if
// Purpose : Operand/result bundle of the bit-serial adder.
// Signals : in_valid/in_ready   operand handshake (A, B, Cin)
//           out_valid/out_ready result handshake (S, Cout, Ovf)
//           busy                adder is computing or holding a result
// Modports: master - producer/consumer side (testbench or upstream logic)
//           slave  - adder side
// Rev     : 1.0  initial release
// ============================================================================
interface serial_adder_if
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             Ovf;
   logic             busy;

   modport master (
      output in_valid, A, B, Cin, out_ready,
      input  in_ready, out_valid, S, Cout, Ovf, busy
   );

   modport slave (
      input  in_valid, A, B, Cin, out_ready,
      output in_ready, out_valid, S, Cout, Ovf, busy
   );

endinterface : serial_adder_if
`default_nettype wire

// File: rtl/serial_adder_dff.sv
`default_nettype none
// ============================================================================
// Module  : dff
// Purpose : Generic W-bit D flip-flop with synchronous active-high reset to 0.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous reset, active-high, clears o_q
//           i_d  - next value
//           o_q  - registered value
// Rev     : 1.0  initial release
// ============================================================================
module dff #(
   parameter int W = 1
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic [W-1:0] i_d,
   output logic      [W-1:0] o_q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         o_q <= '0;
      end else begin
         o_q <= i_d;
      end
   end

endmodule : dff
`default_nettype wire

// File: rtl/serial_adder_fulladder1.sv
`default_nettype none
// ============================================================================
// Module  : fulladder1
// Purpose : Single-bit combinational full adder cell.
// Ports   : i_a, i_b - operand bits
//           i_cin    - carry in
//           o_sum    - sum bit
//           o_cout   - carry out
// Rev     : 1.0  initial release
// ============================================================================
module fulladder1 (
   input  wire logic i_a,
   input  wire logic i_b,
   input  wire logic i_cin,
   output logic      o_sum,
   output logic      o_cout
);

   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule : fulladder1
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder
// Purpose : Bit-serial adder. Accepts WIDTH-bit operands A, B and carry-in,
//           then computes the sum LSB-first, one bit per clock, through a
//           single full-adder cell and a registered carry. The finished
//           result is held until the consumer accepts it.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous reset, active-high
//           bus  - serial_adder_if.slave
//                  in_valid/in_ready, A, B, Cin   operand side
//                  out_valid/out_ready, S, Cout   result side
//                  Ovf  two's-complement overflow of the result
//                  busy high while computing or holding a result
// Timing  : out_valid rises WIDTH edges after the accepting edge; minimum
//           initiation interval is WIDTH+2 cycles.
// Rev     : 1.0  initial release
// ============================================================================
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  wire logic      clk,
   input  wire logic      rst,
   serial_adder_if.slave  bus
);

   // ------------------------------------------------------------------------
   // Parameter range guard
   // ------------------------------------------------------------------------
   if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
      $error("serial_adder: WIDTH must be in 2..64");
   end

   localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

   // ------------------------------------------------------------------------
   // Register outputs (q) and next-state values (d)
   // ------------------------------------------------------------------------
   logic [1:0]       r_state_q;
   logic [1:0]       w_state_d;
   logic [CNT_W-1:0] r_cnt_q;
   logic [CNT_W-1:0] w_cnt_d;
   logic             r_carry_q;
   logic             w_carry_d;
   logic             r_msb_cin_q;
   logic             w_msb_cin_d;
   logic [WIDTH-1:0] r_a_sh_q;
   logic [WIDTH-1:0] w_a_sh_d;
   logic [WIDTH-1:0] r_b_sh_q;
   logic [WIDTH-1:0] w_b_sh_d;
   logic [WIDTH-1:0] r_s_sh_q;
   logic [WIDTH-1:0] w_s_sh_d;

   state_t w_state;
   state_t w_state_next;

   logic w_fa_sum;
   logic w_fa_cout;

   assign w_state   = state_t'(r_state_q);
   assign w_state_d = w_state_next;

   // ------------------------------------------------------------------------
   // Register cells
   // ------------------------------------------------------------------------
   dff #(.W(2)) u_state_reg (
      .clk (clk),
      .rst (rst),
      .i_d (w_state_d),
      .o_q (r_state_q)
   );

   dff #(.W(CNT_W)) u_cnt_reg (
      .clk (clk),
      .rst (rst),
      .i_d (w_cnt_d),
      .o_q (r_cnt_q)
   );

   dff #(.W(1)) u_carry_reg (
      .clk (clk),
      .rst (rst),
      .i_d (w_carry_d),
      .o_q (r_carry_q)
   );

   dff #(.W(1)) u_msb_cin_reg (
      .clk (clk),
      .rst (rst),
      .i_d (w_msb_cin_d),
      .o_q (r_msb_cin_q)
   );

   dff #(.W(WIDTH)) u_a_sh_reg (
      .clk (clk),
      .rst (rst),
      .i_d (w_a_sh_d),
      .o_q (r_a_sh_q)
   );

   dff #(.W(WIDTH)) u_b_sh_reg (
      .clk (clk),
      .rst (rst),
      .i_d (w_b_sh_d),
      .o_q (r_b_sh_q)
   );

   dff #(.W(WIDTH)) u_s_sh_reg (
      .clk (clk),
      .rst (rst),
      .i_d (w_s_sh_d),
      .o_q (r_s_sh_q)
   );

   // ------------------------------------------------------------------------
   // The one and only arithmetic cell: always fed from the low operand bits
   // and the stored carry.
   // ------------------------------------------------------------------------
   fulladder1 u_fa (
      .i_a    (r_a_sh_q[0]),
      .i_b    (r_b_sh_q[0]),
      .i_cin  (r_carry_q),
      .o_sum  (w_fa_sum),
      .o_cout (w_fa_cout)
   );

   // ------------------------------------------------------------------------
   // Next-state and datapath control
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = w_state;
      w_cnt_d      = r_cnt_q;
      w_carry_d    = r_carry_q;
      w_msb_cin_d  = r_msb_cin_q;
      w_a_sh_d     = r_a_sh_q;
      w_b_sh_d     = r_b_sh_q;
      w_s_sh_d     = r_s_sh_q;

      unique case (w_state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               w_a_sh_d     = bus.A;
               w_b_sh_d     = bus.B;
               w_carry_d    = bus.Cin;
               w_cnt_d      = '0;
               w_s_sh_d     = '0;
               w_state_next = ST_RUN;
            end
         end

         ST_RUN: begin
            // Sum bits enter at the MSB so that after WIDTH shifts bit 0 of
            // the result has arrived at s_sh[0].
            w_s_sh_d  = {w_fa_sum, r_s_sh_q[WIDTH-1:1]};
            w_a_sh_d  = r_a_sh_q >> 1;
            w_b_sh_d  = r_b_sh_q >> 1;
            w_carry_d = w_fa_cout;
            w_cnt_d   = r_cnt_q + 1'b1;
            if (r_cnt_q == C_LAST_BIT) begin
               // Carry into the MSB is the carry register before this last
               // update; kept for the signed-overflow flag.
               w_msb_cin_d  = r_carry_q;
               w_state_next = ST_DONE;
            end
         end

         ST_DONE: begin
            if (bus.out_ready) begin
               w_state_next = ST_IDLE;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs: all driven from registers, never from the adder cell.
   // ------------------------------------------------------------------------
   assign bus.in_ready  = (w_state == ST_IDLE) && !rst;
   assign bus.out_valid = (w_state == ST_DONE);
   assign bus.busy      = (w_state == ST_RUN) || (w_state == ST_DONE);
   assign bus.S         = r_s_sh_q;
   assign bus.Cout      = r_carry_q;
   assign bus.Ovf       = r_msb_cin_q ^ r_carry_q;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_adder
// Purpose : Self-checking bench for serial_adder. Directed cases plus random
//           operands compared with a plain-arithmetic reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_serial_adder;

   localparam int W = 16;

   logic clk;
   logic rst;

   int n_checks;
   int n_pass;

   serial_adder_if #(.WIDTH(W)) bus ();

   serial_adder #(.WIDTH(W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one operation from IDLE. stall = cycles out_ready is held low in
   // DONE; noise = scramble operand inputs and in_valid while computing.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input int stall, input bit noise);
      logic [W:0]   tot;
      logic [W-1:0] es;
      logic         ec;
      logic         eo;
      int           lat;
      bit           seen;

      // Reference model: ordinary integer addition.
      tot = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      es  = tot[W-1:0];
      ec  = tot[W];
      eo  = (a[W-1] == b[W-1]) && (es[W-1] != a[W-1]);

      check("in_ready_idle", bus.in_ready, 1'b1);
      bus.A         = a;
      bus.B         = b;
      bus.Cin       = cin;
      bus.in_valid  = 1'b1;
      bus.out_ready = (stall == 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("busy_run", bus.busy, 1'b1);
      check("in_ready_run", bus.in_ready, 1'b0);

      lat  = 0;
      seen = 1'b0;
      for (int k = 1; k <= W + 8 && !seen; k++) begin
         if (noise) begin
            bus.A        = W'($urandom);
            bus.B        = W'($urandom);
            bus.Cin      = 1'($urandom);
            bus.in_valid = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
         if (bus.out_valid) begin
            seen = 1'b1;
            lat  = k;
         end
      end
      bus.in_valid = 1'b0;
      check("latency", lat, W);

      if (seen) begin
         check("S", bus.S, es);
         check("Cout", bus.Cout, ec);
         check("Ovf", bus.Ovf, eo);
         check("in_ready_done", bus.in_ready, 1'b0);
         for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_S", bus.S, es);
            check("hold_Cout", bus.Cout, ec);
            check("hold_Ovf", bus.Ovf, eo);
            check("hold_in_ready", bus.in_ready, 1'b0);
         end
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         check("release_valid", bus.out_valid, 1'b0);
         check("release_busy", bus.busy, 1'b0);
         check("release_in_ready", bus.in_ready, 1'b1);
      end
      bus.out_ready = 1'b0;
   endtask

   initial begin
      int hit;

      n_checks      = 0;
      n_pass        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.Cin       = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_in_ready_held", bus.in_ready, 1'b0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_S", bus.S, 16'h0000);
      check("rst_Cout", bus.Cout, 1'b0);
      check("rst_Ovf", bus.Ovf, 1'b0);
      check("rst_busy", bus.busy, 1'b0);

      // Directed operations
      run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
      run_op(16'h7FFF, 16'h0000, 1'b1, 0, 1'b0);
      run_op(16'h0F0F, 16'hF0F0, 1'b1, 5, 1'b0);
      run_op(16'h00FF, 16'h0F0F, 1'b0, 1, 1'b1);

      // Reset in the middle of a computation
      bus.A        = 16'hAAAA;
      bus.B        = 16'h5555;
      bus.Cin      = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_out_valid", bus.out_valid, 1'b0);
      check("midrst_S", bus.S, 16'h0000);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      hit = 0;
      for (int k = 0; k < W + 4; k++) begin
         @(posedge clk); #1;
         if (bus.out_valid) hit++;
      end
      check("midrst_no_valid", hit, 0);
      bus.out_ready = 1'b0;
      run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);

      // Random operations
      for (int i = 0; i < 24; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule : tb_serial_adder
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder that computes an N-bit sum one bit per clock, using a single 1-bit full-adder cell plus a registered carry.
- Sits directly upstream of the 1-bit full-adder cell. It holds the operands in shift registers, presents one bit pair plus the stored carry to the cell each cycle, and collects the cell's sum and carry outputs.
- Used where area matters more than latency. Ready/valid handshake on both input and output sides.

Parameters:
- WIDTH, 16, operand/sum width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands A, B, Cin are valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in to bit 0.
- out_valid  output  1  S, Cout, Ovf hold a completed result.
- out_ready  input  1  consumer takes the result this cycle.
- S  output  WIDTH  sum.
- Cout  output  1  carry out of bit WIDTH-1 (unsigned overflow).
- Ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN or DONE.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All flops are reset by rst at a clock edge, not asynchronously.
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: in_ready=1 once rst deasserts (in_ready = state==IDLE && !rst). out_valid=0, busy=0. S, Cout, Ovf, internal shift registers, carry and counter all 0.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - a_sh<=A, b_sh<=B, carry<=Cin, cnt<=0, s_sh<=0.
  - Next state RUN.
  - Without in_valid, remain in IDLE.
- RUN: in_ready=0; A, B, Cin are ignored. Each edge:
  - Cell inputs are a_sh[0], b_sh[0], carry.
  - s_sh <= {sum, s_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1 (zero-fill).
  - carry <= cout; cnt <= cnt+1.
  - When cnt==WIDTH-1, also capture msb_cin<=carry (pre-update) and go to DONE.
- DONE: out_valid=1. Outputs S=s_sh, Cout=carry, Ovf=msb_cin^carry.
  - Outputs stay stable until an edge with out_ready=1; then go to IDLE.
  - in_ready=0 throughout DONE; there is no overlap of a new accept with result delivery.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH bits, one DONE cycle with out_ready=1, then accept again from IDLE).
- S, Cout, Ovf are only meaningful while out_valid=1. Internally they are driven from registers, never combinationally from the cell.
- out_ready while not in DONE: ignored.
- rst asserted in any state, including mid-RUN or DONE: next state IDLE, all registers cleared, any partial result discarded, out_valid=0 from that edge.
- Arithmetic is modulo 2^WIDTH. Counter wrap-around never occurs because the exit is at WIDTH-1.

Decomposition:
- Shared package: state encoding constants (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and default WIDTH.
- One sub-module: the existing 1-bit full-adder cell (fulladder1), instantiated once.
- Registers: use the team's dff cell (clk/rst ports) for state, counter, carry and shift registers.
- No other hierarchy.

Test Plan:
1. rst high 2 cycles, then low -> in_ready=1, out_valid=0, S=0, Cout=0, Ovf=0, busy=0.
2. A=0x1234, B=0x4321, Cin=0, out_ready=1 -> out_valid exactly 16 edges after accept, S=0x5555, Cout=0, Ovf=0, returns to IDLE next edge.
3. A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, Ovf=0. Then A=0x7FFF, B=0x0000, Cin=1 -> S=0x8000, Cout=0, Ovf=1.
4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and S/Cout/Ovf remain stable, in_ready=0. out_ready=1 -> IDLE the next edge.
5. Change A/B/Cin and pulse in_valid during RUN -> ignored; result matches the originally accepted operands (A=0x00FF, B=0x0F0F -> S=0x100E, Cout=0).
6. Assert rst at bit 7 of a RUN -> IDLE next edge, out_valid never rises. Then a new accept of A=0x8000, B=0x8000 -> S=0x0000, Cout=1, Ovf=1.
